// File: rtl/band_fir.sv
// band_fir - per-band FIR reader at the output of the sample queue.
//
// Consumes the left/right stream the queue emits while `sequencing` is high.
// Each sample is multiplied by the matching tap from an external synchronous
// coefficient ROM. The products are summed over up to NUM_TAPS taps, and one
// saturated left/right result pair is presented per sequence.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sequencing  high for one cycle per sample being read from the queue
//   lft_smpl    signed left sample, valid the cycle after its sequencing cycle
//   rght_smpl   signed right sample, same timing as lft_smpl
//   coeff_addr  coefficient ROM read address
//   coeff       signed coefficient, valid the cycle after coeff_addr
//   lft_out     signed filtered left result, held between updates
//   rght_out    signed filtered right result, held between updates
//   valid       one-cycle pulse in the cycle lft_out/rght_out update
module band_fir #(
   parameter int NUM_TAPS = 1021
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sequencing,
   input  logic signed [15:0] lft_smpl,
   input  logic signed [15:0] rght_smpl,
   output logic        [9:0]  coeff_addr,
   input  logic signed [15:0] coeff,
   output logic signed [15:0] lft_out,
   output logic signed [15:0] rght_out,
   output logic               valid
);

   localparam logic [1:0]  IDLE  = 2'd0;
   localparam logic [1:0]  RUN   = 2'd1;
   localparam logic [1:0]  DRAIN = 2'd2;

   localparam logic [10:0] TAPS_C      = 11'(NUM_TAPS);
   localparam logic [9:0]  LAST_ADDR_C = 10'(NUM_TAPS - 1);

   logic [1:0]         state_r;
   logic [1:0]         state_nxt_s;
   logic [1:0]         drain_cnt_r;
   logic [10:0]        tap_cnt_r;
   logic               accept_s;
   logic               start_s;
   logic               drain_done_s;
   logic               st1_vld_r;
   logic               prod_vld_r;
   logic signed [31:0] prod_l_r;
   logic signed [31:0] prod_r_r;
   logic signed [41:0] acc_l_r;
   logic signed [41:0] acc_r_r;

   // Drop the 15 fractional bits (arithmetic shift) and clamp to 16-bit signed.
   function automatic logic signed [15:0] sat_shift(input logic signed [41:0] acc);
      logic signed [26:0] q;
      q = acc[41:15];
      if (q > 27'sd32767) begin
         sat_shift = 16'sh7FFF;
      end else if (q < -27'sd32768) begin
         sat_shift = 16'sh8000;
      end else begin
         sat_shift = q[15:0];
      end
   endfunction

   // Accept and handshake decode.
   // A tap is taken in IDLE or RUN only, and only until NUM_TAPS taps have been
   // taken, so overlong sequences add nothing.
   always_comb begin
      accept_s     = 1'b0;
      start_s      = 1'b0;
      drain_done_s = 1'b0;
      if (sequencing && (state_r != DRAIN) && (tap_cnt_r < TAPS_C)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if ((state_r == IDLE) && sequencing) begin
         start_s = 1'b1;
      end else begin
         start_s = 1'b0;
      end
      if ((state_r == DRAIN) && (drain_cnt_r == 2'd2)) begin
         drain_done_s = 1'b1;
      end else begin
         drain_done_s = 1'b0;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (sequencing) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (sequencing) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_done_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register and drain counter.
   // The drain window counts the three cycles after the last tap: the RUN cycle
   // that sees sequencing low is count 0, and DRAIN holds counts 1 and 2. At
   // count 2 the final product has just landed in the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         drain_cnt_r <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == RUN) && !sequencing) begin
            drain_cnt_r <= 2'd1;
         end else if (state_r == DRAIN) begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
         end else begin
            drain_cnt_r <= 2'd0;
         end
      end
   end

   // Coefficient address: steps on every sequencing cycle, saturates on the last tap, parks at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coeff_addr <= 10'd0;
      end else if (sequencing && (state_r != DRAIN)) begin
         if (coeff_addr == LAST_ADDR_C) begin
            coeff_addr <= coeff_addr;
         end else begin
            coeff_addr <= coeff_addr + 10'd1;
         end
      end else begin
         coeff_addr <= 10'd0;
      end
   end

   // Accepted-tap counter.
   // It holds during RUN gaps and is otherwise cleared, so it is 0 whenever IDLE starts a sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_cnt_r <= 11'd0;
      end else if (accept_s) begin
         tap_cnt_r <= tap_cnt_r + 11'd1;
      end else if (state_r != RUN) begin
         tap_cnt_r <= 11'd0;
      end else begin
         tap_cnt_r <= tap_cnt_r;
      end
   end

   // Multiply stage: sample and coefficient arrive one cycle after the accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st1_vld_r  <= 1'b0;
         prod_vld_r <= 1'b0;
         prod_l_r   <= 32'sd0;
         prod_r_r   <= 32'sd0;
      end else begin
         st1_vld_r  <= accept_s;
         prod_vld_r <= st1_vld_r;
         prod_l_r   <= lft_smpl * coeff;
         prod_r_r   <= rght_smpl * coeff;
      end
   end

   // Accumulate stage.
   // The accumulators are cleared on the edge that starts a sequence. The
   // previous sequence has fully drained by then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_l_r <= 42'sd0;
         acc_r_r <= 42'sd0;
      end else if (start_s) begin
         acc_l_r <= 42'sd0;
         acc_r_r <= 42'sd0;
      end else if (prod_vld_r) begin
         acc_l_r <= acc_l_r + 42'(prod_l_r);
         acc_r_r <= acc_r_r + 42'(prod_r_r);
      end else begin
         acc_l_r <= acc_l_r;
         acc_r_r <= acc_r_r;
      end
   end

   // Output registers load on the final drain cycle; valid pulses alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_out  <= 16'sd0;
         rght_out <= 16'sd0;
         valid    <= 1'b0;
      end else if (drain_done_s) begin
         lft_out  <= sat_shift(acc_l_r);
         rght_out <= sat_shift(acc_r_r);
         valid    <= 1'b1;
      end else begin
         lft_out  <= lft_out;
         rght_out <= rght_out;
         valid    <= 1'b0;
      end
   end

endmodule
